// File: rtl/anc_sample_sched.sv
// Per-sample sequencer: takes one merged sample set, launches the ANC core, and forwards its result.
// A watchdog mutes the output when the core hangs. Saturating counters record timeouts and overruns.
module anc_sample_sched #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TMO_W   = 10,
  parameter int unsigned TMO_MAX = 1000,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  output logic              busy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  tmo_cnt,
  output logic [CNT_W-1:0]  ovr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_EMIT    = 3'd4
  } state_e;

  localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(TMO_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_q;
  logic [TMO_W-1:0]    wd_q;
  logic [DATA_W-1:0]   sample_q;
  logic [CNT_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    ovr_q, ovr_d;
  logic                in_valid_q;
  logic                from_emit_q;
  logic                in_busy;
  logic                ovr_evt;
  logic                tmo_evt;

  assign in_busy = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_EMIT);

  // A new set arriving while busy, or one already waiting when a period ends, is a missed period.
  assign ovr_evt = init_done && in_valid &&
                   ((in_busy && !in_valid_q) ||
                    ((state_q == S_WAIT_IN) && from_emit_q && in_valid_q));

  assign tmo_evt = init_done && (state_q == S_RUN) && !core_done && (wd_q == WD_LAST);

  // Saturating status counters; clear wins over increment.
  always_comb begin
    tmo_d = tmo_q;
    ovr_d = ovr_q;
    if (cnt_clr) begin
      tmo_d = '0;
      ovr_d = '0;
    end else begin
      if (tmo_evt && (tmo_q != CNT_SAT)) tmo_d = tmo_q + CNT_ONE;
      if (ovr_evt && (ovr_q != CNT_SAT)) ovr_d = ovr_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      sample_q    <= '0;
      tmo_q       <= '0;
      ovr_q       <= '0;
      in_valid_q  <= 1'b0;
      from_emit_q <= 1'b0;
    end else begin
      in_valid_q  <= in_valid;
      tmo_q       <= tmo_d;
      ovr_q       <= ovr_d;
      from_emit_q <= 1'b0;
      if (!init_done && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (init_done) state_q <= S_WAIT_IN;
          end
          S_WAIT_IN: begin
            if (in_valid) state_q <= S_START;
          end
          S_START: begin
            wd_q    <= '0;
            state_q <= S_RUN;
          end
          S_RUN: begin
            // A completion in the expiry cycle still counts as a normal result.
            if (core_done) begin
              sample_q <= core_out;
              state_q  <= S_EMIT;
            end else if (wd_q == WD_LAST) begin
              sample_q <= '0;
              state_q  <= S_EMIT;
            end else begin
              wd_q <= wd_q + TMO_W'(1);
            end
          end
          S_EMIT: begin
            from_emit_q <= 1'b1;
            state_q     <= S_WAIT_IN;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready   = (state_q == S_WAIT_IN);
  assign core_start = (state_q == S_START);
  assign out_valid  = (state_q == S_EMIT);
  assign busy       = in_busy;
  assign out_sample = sample_q;
  assign tmo_cnt    = tmo_q;
  assign ovr_cnt    = ovr_q;

endmodule

// File: tb/tb_anc_sample_sched.sv
// Directed bench for anc_sample_sched: per-cycle comparison against a transaction-level model,
// plus literal checks of latencies, mute, saturation, overrun and reset behaviour.
module tb_anc_sample_sched;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TMO_MAX = 1000;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TMO2    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_done, in_valid, core_done, cnt_clr;
  logic [DATA_W-1:0] core_out;
  logic              in_ready, core_start, out_valid, busy;
  logic [DATA_W-1:0] out_sample;
  logic [CNT_W-1:0]  tmo_cnt, ovr_cnt;

  logic              init_done2, in_valid2, core_done2, cnt_clr2;
  logic [DATA_W-1:0] core_out2;
  logic              in_ready2, core_start2, out_valid2, busy2;
  logic [DATA_W-1:0] out_sample2;
  logic [CNT_W-1:0]  tmo_cnt2, ovr_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  anc_sample_sched #(.DATA_W(DATA_W), .TMO_W(10), .TMO_MAX(TMO_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .in_valid(in_valid), .in_ready(in_ready),
    .core_start(core_start), .core_done(core_done), .core_out(core_out),
    .out_valid(out_valid), .out_sample(out_sample), .busy(busy), .cnt_clr(cnt_clr),
    .tmo_cnt(tmo_cnt), .ovr_cnt(ovr_cnt));

  anc_sample_sched #(.DATA_W(DATA_W), .TMO_W(10), .TMO_MAX(TMO2), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .rst(rst), .init_done(init_done2), .in_valid(in_valid2), .in_ready(in_ready2),
    .core_start(core_start2), .core_done(core_done2), .core_out(core_out2),
    .out_valid(out_valid2), .out_sample(out_sample2), .busy(busy2), .cnt_clr(cnt_clr2),
    .tmo_cnt(tmo_cnt2), .ovr_cnt(ovr_cnt2));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transaction-level model: phase of the sample period, cycles spent since launch, and status.
  localparam int PH_OFF = 0, PH_READY = 1, PH_LAUNCH = 2, PH_CORE = 3, PH_OUT = 4;
  int          m_ph = PH_OFF;
  int          m_age = 0;
  logic [15:0] m_sample = '0;
  int          m_tmo = 0, m_ovr = 0;
  bit          m_prev_valid = 0, m_after_out = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = PH_OFF; m_age = 0; m_sample = '0; m_tmo = 0; m_ovr = 0;
      m_prev_valid = 0; m_after_out = 0;
    end else begin
      bit ovr_ev, tmo_ev, was_out;
      int nxt;
      ovr_ev  = init_done && in_valid &&
                ((m_ph >= PH_LAUNCH && !m_prev_valid) ||
                 (m_ph == PH_READY && m_after_out && m_prev_valid));
      tmo_ev  = 0;
      was_out = (m_ph == PH_OUT);
      nxt     = m_ph;
      if (!init_done) nxt = PH_OFF;
      else if (m_ph == PH_OFF) nxt = PH_READY;
      else if (m_ph == PH_READY) begin if (in_valid) nxt = PH_LAUNCH; end
      else if (m_ph == PH_LAUNCH) begin nxt = PH_CORE; m_age = 0; end
      else if (m_ph == PH_CORE) begin
        m_age++;
        if (core_done) begin m_sample = core_out; nxt = PH_OUT; end
        else if (m_age == TMO_MAX) begin m_sample = '0; tmo_ev = 1; nxt = PH_OUT; end
      end else nxt = PH_READY;
      if (cnt_clr) begin m_tmo = 0; m_ovr = 0; end
      else begin
        if (tmo_ev) m_tmo = (m_tmo == 255) ? 255 : m_tmo + 1;
        if (ovr_ev) m_ovr = (m_ovr == 255) ? 255 : m_ovr + 1;
      end
      m_after_out  = was_out && (nxt == PH_READY);
      m_prev_valid = in_valid;
      m_ph         = nxt;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("m_in_ready",   32'(in_ready),   32'(m_ph == PH_READY));
    check("m_core_start", 32'(core_start), 32'(m_ph == PH_LAUNCH));
    check("m_out_valid",  32'(out_valid),  32'(m_ph == PH_OUT));
    check("m_busy",       32'(busy),       32'(m_ph >= PH_LAUNCH));
    check("m_out_sample", 32'(out_sample), 32'(m_sample));
    check("m_tmo_cnt",    32'(tmo_cnt),    32'(m_tmo));
    check("m_ovr_cnt",    32'(ovr_cnt),    32'(m_ovr));
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst = 1'b1; init_done = 0; in_valid = 0; core_done = 0; cnt_clr = 0; core_out = '0;
    init_done2 = 0; in_valid2 = 0; core_done2 = 0; cnt_clr2 = 0; core_out2 = '0;
    step(2);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_sample", 32'(out_sample), 0);
    check("rst_tmo", 32'(tmo_cnt), 0);
    rst = 1'b0;
    step(1);

    // Normal transaction, result 1234 five cycles after launch
    init_done = 1; in_valid = 1;
    step(1);
    check("t1_in_ready", 32'(in_ready), 1);
    step(1);
    in_valid = 0;
    check("t1_core_start", 32'(core_start), 1);
    step(5);
    core_done = 1; core_out = 16'h1234;
    step(1);
    core_done = 0;
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_out_sample", 32'(out_sample), 32'h1234);
    check("t1_tmo", 32'(tmo_cnt), 0);
    step(1);
    check("t1_back_ready", 32'(in_ready), 1);

    // Hung core: muted output TMO_MAX+1 cycles after launch
    in_valid = 1;
    step(1);
    in_valid = 0;
    check("t2_core_start", 32'(core_start), 1);
    k = 0;
    while (!out_valid && k < 1100) begin step(1); k++; end
    check("t2_latency", 32'(k), 1001);
    check("t2_muted", 32'(out_sample), 0);
    check("t2_tmo", 32'(tmo_cnt), 1);
    step(1);

    // Completion in the watchdog expiry cycle wins
    in_valid = 1;
    step(1);
    in_valid = 0;
    step(1000);
    core_done = 1; core_out = 16'hFFFE;
    step(1);
    core_done = 0;
    check("t3_out_valid", 32'(out_valid), 1);
    check("t3_out_sample", 32'(out_sample), 32'hFFFE);
    check("t3_tmo", 32'(tmo_cnt), 1);
    step(1);

    // Overrun during RUN, then a waiting set at period end, then clear
    in_valid = 1;
    step(1);
    in_valid = 0;
    step(2);
    in_valid = 1;
    step(1);
    check("t4_ovr", 32'(ovr_cnt), 1);
    check("t4_busy", 32'(busy), 1);
    step(2);
    core_done = 1; core_out = 16'h0042;
    step(1);
    core_done = 0;
    check("t4_out_sample", 32'(out_sample), 32'h0042);
    step(2);
    check("t4_accept", 32'(core_start), 1);
    check("t4_ovr_wait", 32'(ovr_cnt), 2);
    in_valid = 0;
    step(1);
    in_valid = 1; cnt_clr = 1;
    step(1);
    cnt_clr = 0; in_valid = 0;
    check("t4_clr_ovr", 32'(ovr_cnt), 0);
    check("t4_clr_tmo", 32'(tmo_cnt), 0);
    step(1);
    core_done = 1; core_out = 16'h0042;
    step(1);
    core_done = 0;
    step(1);

    // init_done drop mid-RUN abandons the sample; stray completion ignored
    in_valid = 1;
    step(1);
    in_valid = 0;
    step(3);
    init_done = 0;
    step(1);
    check("t5_busy", 32'(busy), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_hold", 32'(out_sample), 32'h0042);
    core_done = 1; core_out = 16'h7777;
    step(1);
    core_done = 0;
    check("t5_stray", 32'(out_valid), 0);
    check("t5_stray_hold", 32'(out_sample), 32'h0042);

    // Asynchronous reset during EMIT
    init_done = 1;
    step(1);
    in_valid = 1;
    step(1);
    in_valid = 0;
    step(1);
    core_done = 1; core_out = 16'h5555;
    step(1);
    core_done = 0;
    check("t6_emit", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_sample", 32'(out_sample), 0);
    check("t6_rst_busy", 32'(busy), 0);
    step(1);
    rst = 1'b0;
    step(2);

    // Timeout counter saturation on a short-watchdog instance
    init_done2 = 1;
    for (int i = 0; i < 260; i++) begin
      k = 0;
      while (!in_ready2 && k < 20) begin step(1); k++; end
      in_valid2 = 1;
      step(1);
      in_valid2 = 0;
      k = 0;
      while (!out_valid2 && k < 20) begin step(1); k++; end
      check("sat_tmo", 32'(tmo_cnt2), (i + 1 > 255) ? 255 : i + 1);
    end
    check("sat_final", 32'(tmo_cnt2), 255);
    check("sat_muted", 32'(out_sample2), 0);
    check("sat_ovr", 32'(ovr_cnt2), 0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
